// File: rtl/busca_binaria_comparador_pkg.sv
// Shared definitions for the binary-search operand generator.
package busca_pkg;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    CALCULA  = 3'd1,
    COMPARA  = 3'd2,
    FIM_OK   = 3'd3,
    FIM_ERRO = 3'd4
  } estado_t;

  // Worst-case number of comparisons for an n-bit search range.
  function automatic int max_tentativas(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/busca_binaria_comparador_if.sv
// Comparator handshake and result bus between the search engine and the datapath.
interface busca_binaria_comparador_if #(
  parameter int N = 3
);
  logic         iniciar;
  logic         menor;
  logic         maior;
  logic         igual;
  logic [N-1:0] palpite;
  logic [N:0]   tentativas;
  logic         ocupado;
  logic         pronto;
  logic         acertou;
  logic         erro;

  modport slave (
    input  iniciar, menor, maior, igual,
    output palpite, tentativas, ocupado, pronto, acertou, erro
  );

  modport master (
    output iniciar, menor, maior, igual,
    input  palpite, tentativas, ocupado, pronto, acertou, erro
  );
endinterface

// File: rtl/busca_binaria_comparador_fsm.sv
// Search controller: state register, next-state logic and Moore flag decode.
//  state    | meaning
//  INICIAL  | idle after reset, waiting for iniciar
//  CALCULA  | register midpoint guess, count the attempt
//  COMPARA  | comparator has settled, narrow the range or finish
//  FIM_OK   | guess equals the hidden value
//  FIM_ERRO | inconsistent comparator answer or empty range
module busca_fsm
  import busca_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         menor,
  input  logic         maior,
  input  logic         igual,
  input  logic [N-1:0] palpite,
  input  logic [N:0]   low,
  input  logic [N:0]   high,
  output estado_t      estado,
  output estado_t      estado_prox,
  output logic         ocupado,
  output logic         pronto,
  output logic         acertou,
  output logic         erro
);

  localparam logic [N-1:0] PALPITE_MAX = {N{1'b1}};
  localparam logic [N:0]   UM          = {{N{1'b0}}, 1'b1};

  estado_t    estado_q, estado_d;
  logic [2:0] flags;
  logic [N:0] palpite_ext;

  assign flags       = {menor, maior, igual};
  assign palpite_ext = {1'b0, palpite};

  // Next state; range-boundary checks happen before any increment/decrement.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL, FIM_OK, FIM_ERRO: if (iniciar) estado_d = CALCULA;
      CALCULA: estado_d = COMPARA;
      COMPARA: begin
        if (!$onehot(flags))                  estado_d = FIM_ERRO;
        else if (igual)                       estado_d = FIM_OK;
        else if (maior) begin
          if (palpite == PALPITE_MAX)         estado_d = FIM_ERRO;
          else if ((palpite_ext + UM) > high) estado_d = FIM_ERRO;
          else                                estado_d = CALCULA;
        end else begin
          if (palpite == '0)                  estado_d = FIM_ERRO;
          else if (low > (palpite_ext - UM))  estado_d = FIM_ERRO;
          else                                estado_d = CALCULA;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end

  // Moore output decode from the state register only.
  always_comb begin
    ocupado = 1'b0;
    pronto  = 1'b0;
    acertou = 1'b0;
    erro    = 1'b0;
    case (estado_q)
      CALCULA, COMPARA: ocupado = 1'b1;
      FIM_OK:   begin pronto = 1'b1; acertou = 1'b1; end
      FIM_ERRO: begin pronto = 1'b1; erro    = 1'b1; end
      default: ;
    endcase
  end

  assign estado      = estado_q;
  assign estado_prox = estado_d;

endmodule

// File: rtl/busca_binaria_comparador.sv
// Binary-search operand generator driving guess B into a magnitude comparator.
module busca_binaria_comparador
  import busca_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  busca_binaria_comparador_if.slave    bus
);

  localparam int           TW   = max_tentativas(N);
  localparam logic [N:0]   TOPO = {1'b0, {N{1'b1}}};
  localparam logic [N:0]   UM   = {{N{1'b0}}, 1'b1};

  estado_t       estado, estado_prox;
  logic [N-1:0]  palpite_q, palpite_d;
  logic [TW-1:0] tentativas_q, tentativas_d;
  logic [N:0]    low_q, low_d;
  logic [N:0]    high_q, high_d;
  logic [N:0]    soma;
  logic [N:0]    palpite_ext;

  busca_fsm #(.N(N)) u_fsm (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (bus.iniciar),
    .menor       (bus.menor),
    .maior       (bus.maior),
    .igual       (bus.igual),
    .palpite     (palpite_q),
    .low         (low_q),
    .high        (high_q),
    .estado      (estado),
    .estado_prox (estado_prox),
    .ocupado     (bus.ocupado),
    .pronto      (bus.pronto),
    .acertou     (bus.acertou),
    .erro        (bus.erro)
  );

  // low+high never overflows at N+1 bits since both stay within 0..2**N-1.
  assign soma        = low_q + high_q;
  assign palpite_ext = {1'b0, palpite_q};

  // Datapath updates keyed on the current state; range narrows only when continuing.
  always_comb begin
    palpite_d    = palpite_q;
    tentativas_d = tentativas_q;
    low_d        = low_q;
    high_d       = high_q;
    case (estado)
      INICIAL, FIM_OK, FIM_ERRO: begin
        if (bus.iniciar) begin
          low_d        = '0;
          high_d       = TOPO;
          tentativas_d = '0;
        end
      end
      CALCULA: begin
        palpite_d    = N'(soma >> 1);
        tentativas_d = tentativas_q + UM;
      end
      COMPARA: begin
        if (estado_prox == CALCULA) begin
          if (bus.maior) low_d  = palpite_ext + UM;
          else           high_d = palpite_ext - UM;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      palpite_q    <= '0;
      tentativas_q <= '0;
      low_q        <= '0;
      high_q       <= TOPO;
    end else begin
      palpite_q    <= palpite_d;
      tentativas_q <= tentativas_d;
      low_q        <= low_d;
      high_q       <= high_d;
    end
  end

  assign bus.palpite    = palpite_q;
  assign bus.tentativas = tentativas_q;

endmodule

// File: tb/tb_busca_binaria_comparador.sv
// Closed-loop bench: a 7485-style comparator model answers the DUT's guesses.
module tb_busca_binaria_comparador;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  busca_binaria_comparador_if #(.N(3)) bus();

  busca_binaria_comparador #(.N(3)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [2:0] secret      = 3'd0;
  logic       force_en    = 1'b0;
  logic [2:0] force_flags = 3'b000; // {menor, maior, igual}
  int total = 0;
  int bad   = 0;

  // Comparator model, cascade inputs ALBi=0 AGBi=0 AEBi=1.
  always_comb begin
    if (force_en) begin
      {bus.menor, bus.maior, bus.igual} = force_flags;
    end else begin
      bus.menor = (secret < bus.palpite);
      bus.maior = (secret > bus.palpite);
      bus.igual = (secret == bus.palpite);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " palpite"},    32'(bus.palpite),    0);
    check({tag, " tentativas"}, 32'(bus.tentativas), 0);
    check({tag, " ocupado"},    32'(bus.ocupado),    0);
    check({tag, " pronto"},     32'(bus.pronto),     0);
    check({tag, " acertou"},    32'(bus.acertou),    0);
    check({tag, " erro"},       32'(bus.erro),       0);
  endtask

  task automatic pulse_start();
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
  endtask

  // Full search: k guesses listed in seq (first guess in seq[2:0]).
  task automatic search(input string tag, input int k, input logic [11:0] seq, input logic ok);
    pulse_start();
    check({tag, " start ocupado"},    32'(bus.ocupado),    1);
    check({tag, " start pronto"},     32'(bus.pronto),     0);
    check({tag, " start acertou"},    32'(bus.acertou),    0);
    check({tag, " start erro"},       32'(bus.erro),       0);
    check({tag, " start tentativas"}, 32'(bus.tentativas), 0);
    for (int i = 0; i < k; i++) begin
      tick();
      check($sformatf("%s palpite%0d", tag, i), 32'(bus.palpite), 32'(seq[3*i +: 3]));
      check($sformatf("%s tent%0d", tag, i), 32'(bus.tentativas), 32'(i + 1));
      tick();
      if (i < k - 1) check($sformatf("%s early pronto%0d", tag, i), 32'(bus.pronto), 0);
    end
    check({tag, " pronto"},     32'(bus.pronto),     1);
    check({tag, " ocupado"},    32'(bus.ocupado),    0);
    check({tag, " acertou"},    32'(bus.acertou),    32'(ok));
    check({tag, " erro"},       32'(bus.erro),       32'(!ok));
    check({tag, " tentativas"}, 32'(bus.tentativas), 32'(k));
  endtask

  initial begin
    bus.iniciar = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("idle");

    secret = 3'd5;
    search("a5", 2, {3'd0, 3'd0, 3'd5, 3'd3}, 1'b1);

    secret = 3'd0;
    search("a0", 3, {3'd0, 3'd0, 3'd1, 3'd3}, 1'b1);

    secret = 3'd7;
    search("a7", 4, {3'd7, 3'd6, 3'd5, 3'd3}, 1'b1);
    tick();
    check("a7 hold palpite", 32'(bus.palpite), 7);
    check("a7 hold pronto",  32'(bus.pronto),  1);

    force_en    = 1'b1;
    force_flags = 3'b011;
    search("multi", 1, {3'd0, 3'd0, 3'd0, 3'd3}, 1'b0);

    force_flags = 3'b010;
    search("maiorfix", 4, {3'd7, 3'd6, 3'd5, 3'd3}, 1'b0);
    force_en = 1'b0;

    secret = 3'd6;
    pulse_start();
    tick();
    check("ign palpite0", 32'(bus.palpite), 3);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    check("ign tent", 32'(bus.tentativas), 1);
    check("ign ocupado", 32'(bus.ocupado), 1);
    tick();
    check("ign palpite1", 32'(bus.palpite), 5);
    tick();
    tick();
    check("ign palpite2", 32'(bus.palpite), 6);
    tick();
    check("ign acertou",    32'(bus.acertou),    1);
    check("ign tentativas", 32'(bus.tentativas), 3);

    pulse_start();
    tick();
    tick();
    check("mid ocupado", 32'(bus.ocupado), 1);
    rst = 1'b1;
    tick();
    check_idle("midreset");
    rst = 1'b0;
    tick();
    check_idle("postreset");

    secret = 3'd5;
    search("r5", 2, {3'd0, 3'd0, 3'd5, 3'd3}, 1'b1);
    secret = 3'd2;
    search("r2", 3, {3'd0, 3'd2, 3'd1, 3'd3}, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
